// File: rtl/mux_reg_n_if.sv
// Channel bus for mux_reg_n: packed input channels, select/strobe controls
// and the registered result.
interface mux_reg_n_if #(
    parameter int WIDTH = 32,
    parameter int N     = 9,
    parameter int SELW  = 4
);
    logic [N*WIDTH-1:0] In;
    logic [SELW-1:0]    Sinal;
    logic               Mode;
    logic               Load;
    logic               ErrClr;
    logic [WIDTH-1:0]   Out;
    logic               Valid;
    logic [SELW-1:0]    Chan;
    logic               Err;

    modport master (
        output In, Sinal, Mode, Load, ErrClr,
        input  Out, Valid, Chan, Err
    );

    modport slave (
        input  In, Sinal, Mode, Load, ErrClr,
        output Out, Valid, Chan, Err
    );
endinterface

// File: rtl/mux_reg_n.sv
// Registered N-way channel multiplexer with direct-select and auto-scan
// capture modes and a sticky out-of-range select flag.
module mux_reg_n #(
    parameter int WIDTH = 32,
    parameter int N     = 9,
    parameter int SELW  = 4
) (
    input  logic        clk,
    input  logic        reset,
    mux_reg_n_if.slave  bus
);

    logic [WIDTH-1:0] out_q;
    logic [SELW-1:0]  chan_q;
    logic [SELW-1:0]  scan_cnt;
    logic             valid_q;
    logic             err_q;

    logic             sel_ok;
    logic             scan_last;
    logic             err_evt;
    int               sel_idx;
    logic [WIDTH-1:0] sel_data;

    // sel_idx is always a legal channel: scan_cnt never reaches N and an
    // out-of-range direct select falls back to channel 0 (its data is unused).
    always_comb begin
        sel_ok    = int'(bus.Sinal) < N;
        scan_last = int'(scan_cnt) == N - 1;
        err_evt   = bus.Load && !bus.Mode && !sel_ok;
        sel_idx   = 0;
        if (bus.Mode)
            sel_idx = int'(scan_cnt);
        else if (sel_ok)
            sel_idx = int'(bus.Sinal);
        sel_data  = bus.In[sel_idx*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            chan_q   <= '0;
            scan_cnt <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.Mode)
                scan_cnt <= '0;

            if (bus.Load) begin
                if (bus.Mode) begin
                    out_q    <= sel_data;
                    chan_q   <= scan_cnt;
                    valid_q  <= 1'b1;
                    scan_cnt <= scan_last ? '0 : scan_cnt + SELW'(1);
                end else if (sel_ok) begin
                    out_q   <= sel_data;
                    chan_q  <= bus.Sinal;
                    valid_q <= 1'b1;
                end
            end

            // A new error in the same cycle beats a clear request.
            if (err_evt)
                err_q <= 1'b1;
            else if (bus.ErrClr)
                err_q <= 1'b0;
        end
    end

    assign bus.Out   = out_q;
    assign bus.Chan  = chan_q;
    assign bus.Valid = valid_q;
    assign bus.Err   = err_q;

endmodule

// File: tb/tb_mux_reg_n.sv
// Bench for mux_reg_n: directed scenarios plus random traffic against a
// behavioural model, and scan-wrap checks on N=2 and N=16 instances.
module tb_mux_reg_n;

    localparam int W = 32;
    localparam int N = 9;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_reg_n_if #(.WIDTH(W), .N(N),  .SELW(S)) bus   ();
    mux_reg_n_if #(.WIDTH(8), .N(2),  .SELW(1)) bus2  ();
    mux_reg_n_if #(.WIDTH(8), .N(16), .SELW(4)) bus16 ();

    mux_reg_n #(.WIDTH(W), .N(N),  .SELW(S)) dut   (.clk(clk), .reset(reset), .bus(bus.slave));
    mux_reg_n #(.WIDTH(8), .N(2),  .SELW(1)) dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));
    mux_reg_n #(.WIDTH(8), .N(16), .SELW(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs must show after the last edge.
    logic [W-1:0] m_out;
    int           m_chan;
    logic         m_valid;
    logic         m_err;
    int           m_pos;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_chan = 0; m_valid = 1'b0; m_err = 1'b0; m_pos = 0;
    endtask

    task automatic cycle();
        int  s;
        bit  ev;
        @(posedge clk);
        ev = 1'b0;
        s  = int'(bus.Sinal);
        if (reset) begin
            model_reset();
        end else begin
            m_valid = 1'b0;
            if (bus.Load && bus.Mode) begin
                m_out   = bus.In[m_pos*W +: W];
                m_chan  = m_pos;
                m_valid = 1'b1;
                m_pos   = (m_pos + 1) % N;
            end else if (bus.Load) begin
                if (s < N) begin
                    m_out   = bus.In[s*W +: W];
                    m_chan  = s;
                    m_valid = 1'b1;
                end else begin
                    ev = 1'b1;
                end
            end
            if (!bus.Mode) m_pos = 0;
            if (ev) m_err = 1'b1;
            else if (bus.ErrClr) m_err = 1'b0;
        end
        #1;
        check("out",   bus.Out,   m_out);
        check("chan",  bus.Chan,  m_chan);
        check("valid", bus.Valid, m_valid);
        check("err",   bus.Err,   m_err);
    endtask

    task automatic drive(input int sel, input bit mode, input bit load, input bit clr);
        bus.Sinal  = S'(sel);
        bus.Mode   = mode;
        bus.Load   = load;
        bus.ErrClr = clr;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) bus.In[k*W +: W] = 32'hA000_0000 + k;
        drive(5, 1'b0, 1'b1, 1'b0);
        bus2.In = {8'h11, 8'h10};
        for (int k = 0; k < 16; k++) bus16.In[k*8 +: 8] = 8'(16 + k);
        bus2.Sinal = '0;  bus2.Mode = 1'b1;  bus2.Load = 1'b1;  bus2.ErrClr = 1'b0;
        bus16.Sinal = '0; bus16.Mode = 1'b1; bus16.Load = 1'b1; bus16.ErrClr = 1'b0;

        // Load is held high through reset and must be ignored.
        cycle();
        cycle();
        check("reset_out", bus.Out, 0);
        reset = 1'b0;

        // Direct select of channel 5, then an idle cycle.
        drive(5, 1'b0, 1'b1, 1'b0);
        cycle();
        check("direct_out", bus.Out, 64'hA000_0005);
        drive(5, 1'b0, 1'b0, 1'b0);
        cycle();

        // Out-of-range selects hold data and set Err; clear afterwards.
        drive(9, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(15, 1'b0, 1'b1, 1'b0);
        cycle();
        check("oor_hold_chan", bus.Chan, 5);
        drive(0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("errclr", bus.Err, 0);

        // Clear coinciding with an out-of-range load: set wins.
        drive(12, 1'b0, 1'b1, 1'b1);
        cycle();
        check("set_wins", bus.Err, 1);
        drive(0, 1'b0, 1'b0, 1'b1);
        cycle();

        // Scan for 11 cycles: 0..8 then wrap to 0,1.
        for (int i = 0; i < 11; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0);
            cycle();
            check("scan_seq", bus.Chan, i % N);
            check("scan_valid", bus.Valid, 1);
        end

        // Restart scan, run to channel 3, drop Mode without Load, re-enter.
        drive(0, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        check("scan_to3", bus.Chan, 3);
        drive(0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(0, 1'b1, 1'b1, 1'b0);
        cycle();
        check("mode_reentry", bus.Chan, 0);

        // Asynchronous reset between edges mid-scan.
        for (int i = 0; i < 3; i++) cycle();
        #2 reset = 1'b1;
        #1;
        check("async_out",   bus.Out,   0);
        check("async_chan",  bus.Chan,  0);
        check("async_valid", bus.Valid, 0);
        model_reset();
        cycle();
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0);
        cycle();
        check("post_reset_scan", bus.Chan, 0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) bus.In[k*W +: W] = $urandom;
            drive($urandom_range(0, 15), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
            cycle();
        end

        // Parameter sweep: restart both scans at 0 and watch the wrap.
        drive(0, 1'b0, 1'b0, 1'b0);
        bus2.Mode = 1'b0;
        bus16.Mode = 1'b0;
        cycle();
        bus2.Mode = 1'b1;
        bus16.Mode = 1'b1;
        for (int i = 0; i < 36; i++) begin
            cycle();
            check("n2_chan",    bus2.Chan,   i % 2);
            check("n2_out",     bus2.Out,    16 + (i % 2));
            check("n2_valid",   bus2.Valid,  1);
            check("n16_chan",   bus16.Chan,  i % 16);
            check("n16_out",    bus16.Out,   16 + (i % 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_reg_n.md
MUX_REG_N -- requirements
Module: mux_reg_n

Interface
REQ-001 The module SHALL expose the parameter WIDTH, default 32, meaning the data width of every channel in bits.
REQ-002 The module SHALL expose the parameter N, default 9, meaning the number of input channels (legal range 2..16).
REQ-003 The module SHALL expose the parameter SELW, default 4, meaning the select width; SELW SHALL satisfy 2^SELW >= N.
REQ-004 Port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port In, input, N*WIDTH bits: packed channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 Port Sinal, input, SELW bits: channel select, used in direct mode only.
REQ-008 Port Mode, input, 1 bit: 0 = direct select, 1 = auto-scan.
REQ-009 Port Load, input, 1 bit: capture strobe.
REQ-010 Port ErrClr, input, 1 bit: clears the sticky error flag.
REQ-011 Port Out, output, WIDTH bits: registered selected data.
REQ-012 Port Valid, output, 1 bit: one-cycle pulse marking a new Out value.
REQ-013 Port Chan, output, SELW bits: index of the channel currently held in Out.
REQ-014 Port Err, output, 1 bit: sticky out-of-range select flag.

Function
REQ-015 Direct mode, Load=1, Sinal<N: Out SHALL take In channel Sinal at the next edge, Chan SHALL take Sinal, and Valid SHALL be 1 in the following cycle.
REQ-016 Direct mode, Load=1, Sinal>=N: Out and Chan SHALL hold, Valid SHALL stay 0, and Err SHALL set to 1; no latch or X SHALL be produced.
REQ-017 Scan mode, Load=1: Out SHALL take In channel ScanCnt, Chan SHALL take ScanCnt, Valid SHALL pulse, and ScanCnt SHALL advance.
REQ-018 ScanCnt SHALL be an internal SELW-bit counter that wraps from N-1 to 0, never reaching N.
REQ-019 With Load=0 in either mode, Out, Chan and ScanCnt SHALL hold, and Valid SHALL be 0.
REQ-020 While Mode=0, ScanCnt SHALL be forced to 0, so every entry into scan mode starts at channel 0.
REQ-021 Mode SHALL be sampled in the same cycle as Load; a Mode change and Load in the same cycle SHALL use the new Mode value.
REQ-022 When ErrClr=1 and no error occurs in that cycle, Err SHALL clear at the next edge.
REQ-023 When ErrClr=1 coincides with an out-of-range Load, Err SHALL be 1 (set wins).
REQ-024 Load-to-Out latency SHALL be exactly 1 cycle, and back-to-back Loads SHALL produce one Valid pulse per Load with no bubbles.
REQ-025 Output selection SHALL depend only on registered state; no output SHALL have a combinational path from any input.

Reset
REQ-026 While reset=1, regardless of clk: Out=0, Chan=0, Valid=0, Err=0, ScanCnt=0.
REQ-027 A reset asserted mid-scan SHALL abandon the scan; after release the first scan Load SHALL select channel 0.
REQ-028 Inputs SHALL be ignored while reset=1, including a Load in the release cycle's preceding edge.

Verification
REQ-029 Direct: WIDTH=32, N=9, In ch k = 0xA0000000+k, Mode=0, Sinal=5, Load pulse -> next cycle Out=0xA0000005, Chan=5, Valid=1 for one cycle.
REQ-030 Out-of-range: Sinal=9 then 15 with Load -> Out/Chan unchanged from prior value, Valid=0, Err=1; ErrClr pulse -> Err=0.
REQ-031 Scan wrap: Mode=1, Load held high for 11 cycles -> Chan sequence 0,1,...,8,0,1 with Valid high every cycle.
REQ-032 Mode switch: scan to Chan=3, set Mode=0 for one cycle without Load, then Mode=1 with Load -> Chan=0.
REQ-033 Async reset: assert reset between clock edges mid-scan -> outputs go to 0 immediately, not at the next edge; after release, the first scan Load gives Chan=0.
REQ-034 Simultaneous events: ErrClr=1 with out-of-range Load -> Err=1; parameter sweep N=2 (SELW=1) and N=16 (SELW=4) -> wrap at N-1 verified.
